// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for LDM/STM-style multiple register load/store.
// Walks the captured register list lowest index first, issuing one memory beat
// per selected register at ascending word addresses, then reports the base
// writeback value for one cycle in DONE.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic [15:0]       reg_list_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic              p_bit_in,
    input  logic              u_bit_in,
    input  logic              l_bit_in,
    input  logic              w_bit_in,
    input  logic              mem_ready_in,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [3:0]        reg_addr_out,
    output logic              reg_we_out,
    output logic              wb_en_out,
    output logic [ADDR_W-1:0] wb_addr_out,
    output logic              busy_out,
    output logic              done_out
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic [15:0]       pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_val_q, wb_val_d;
    logic              load_q, load_d;
    logic              wb_req_q, wb_req_d;

    // Registered outputs
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        reg_addr_q, reg_addr_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [4:0]        list_cnt;
    logic [ADDR_W-1:0] list_bytes;
    logic [ADDR_W-1:0] first_addr;
    logic [3:0]        low_idx;
    logic              xfer_next;
    logic              done_next;

    // Number of registers in the incoming list
    always_comb begin
        list_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            list_cnt = list_cnt + 5'(reg_list_in[i]);
        end
    end

    assign list_bytes = ADDR_W'(list_cnt) << 2;

    // Lowest transfer address for the four addressing modes; beats then ascend
    always_comb begin
        unique case ({p_bit_in, u_bit_in})
            2'b01:   first_addr = base_addr_in;
            2'b11:   first_addr = base_addr_in + ADDR_W'(4);
            2'b00:   first_addr = base_addr_in - list_bytes + ADDR_W'(4);
            default: first_addr = base_addr_in - list_bytes;
        endcase
    end

    // FSM next state, pending mask and address walk
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        wb_val_d  = wb_val_q;
        load_d    = load_q;
        wb_req_d  = wb_req_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    pending_d = reg_list_in;
                    addr_d    = first_addr;
                    wb_val_d  = u_bit_in ? (base_addr_in + list_bytes)
                                         : (base_addr_in - list_bytes);
                    load_d    = l_bit_in;
                    wb_req_d  = w_bit_in;
                    state_d   = (reg_list_in == 16'd0) ? StDone : StXfer;
                end
            end
            StXfer: begin
                // mem_req is always high in XFER, so ready alone completes the beat
                if (mem_ready_in) begin
                    pending_d = pending_q & (pending_q - 16'd1);
                    addr_d    = addr_q + ADDR_W'(4);
                    if (pending_d == 16'd0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                pending_d = '0;
                addr_d    = '0;
            end
            default: begin
                state_d   = StIdle;
                pending_d = '0;
                addr_d    = '0;
            end
        endcase
    end

    // Register index of the next beat: lowest set bit of the next pending mask
    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_d[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Next values of the registered outputs, decoded from the next state
    always_comb begin
        xfer_next  = (state_d == StXfer);
        done_next  = (state_d == StDone);
        mem_req_d  = xfer_next;
        mem_we_d   = xfer_next & ~load_d;
        mem_addr_d = xfer_next ? addr_d : '0;
        reg_addr_d = xfer_next ? low_idx : 4'd0;
        busy_d     = (state_d != StIdle);
        done_d     = done_next;
        // Only a list with beats reaches DONE from XFER; empty lists never write back
        wb_en_d    = done_next & wb_req_d & (state_q == StXfer);
        wb_addr_d  = done_next ? wb_val_d : '0;
    end

    // State and output registers with asynchronous active-high reset
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            load_q     <= 1'b0;
            wb_req_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            reg_addr_q <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            wb_val_q   <= wb_val_d;
            load_q     <= load_d;
            wb_req_q   <= wb_req_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            reg_addr_q <= reg_addr_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_req_out  = mem_req_q;
    assign mem_we_out   = mem_we_q;
    assign mem_addr_out = mem_addr_q;
    assign reg_addr_out = reg_addr_q;
    // Load data strobe follows the memory handshake in the same cycle
    assign reg_we_out   = mem_req_q & mem_ready_in & load_q;
    assign wb_en_out    = wb_en_q;
    assign wb_addr_out  = wb_addr_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed scenarios with literal
// expectations plus randomized transfers checked every cycle against a
// transaction-level model (queue of expected beats per accepted start).
module tb_ldm_stm_sequencer;

    localparam int PIdle = 0;
    localparam int PXfer = 1;
    localparam int PDone = 2;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic [15:0] reg_list_in = '0;
    logic [31:0] base_addr_in = '0;
    logic        p_bit_in = 1'b0;
    logic        u_bit_in = 1'b0;
    logic        l_bit_in = 1'b0;
    logic        w_bit_in = 1'b0;
    logic        mem_ready_in = 1'b0;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  reg_addr_out;
    logic        reg_we_out;
    logic        wb_en_out;
    logic [31:0] wb_addr_out;
    logic        busy_out;
    logic        done_out;

    always #5 clk_in = ~clk_in;

    ldm_stm_sequencer #(.ADDR_W(32)) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .start_in     (start_in),
        .reg_list_in  (reg_list_in),
        .base_addr_in (base_addr_in),
        .p_bit_in     (p_bit_in),
        .u_bit_in     (u_bit_in),
        .l_bit_in     (l_bit_in),
        .w_bit_in     (w_bit_in),
        .mem_ready_in (mem_ready_in),
        .mem_req_out  (mem_req_out),
        .mem_we_out   (mem_we_out),
        .mem_addr_out (mem_addr_out),
        .reg_addr_out (reg_addr_out),
        .reg_we_out   (reg_we_out),
        .wb_en_out    (wb_en_out),
        .wb_addr_out  (wb_addr_out),
        .busy_out     (busy_out),
        .done_out     (done_out)
    );

    int total = 0;
    int bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    int          m_phase = PIdle;
    int          q_idx[$];
    logic [31:0] q_addr[$];
    logic        m_load = 1'b0;
    logic        m_wb_en = 1'b0;
    logic [31:0] m_wb = '0;
    int          m_n;
    int          m_k;
    logic [31:0] m_first;

    initial begin
        forever begin
            @(posedge clk_in or posedge reset_in);
            if (reset_in) begin
                m_phase = PIdle;
                q_idx.delete();
                q_addr.delete();
            end else begin
                case (m_phase)
                    PIdle: begin
                        if (start_in) begin
                            m_n = $countones(reg_list_in);
                            if (u_bit_in)
                                m_first = base_addr_in + (p_bit_in ? 32'd4 : 32'd0);
                            else
                                m_first = base_addr_in - 32'(4 * m_n) +
                                          (p_bit_in ? 32'd0 : 32'd4);
                            m_wb = u_bit_in ? base_addr_in + 32'(4 * m_n)
                                            : base_addr_in - 32'(4 * m_n);
                            m_wb_en = w_bit_in && (m_n != 0);
                            m_load = l_bit_in;
                            m_k = 0;
                            for (int i = 0; i < 16; i++) begin
                                if (reg_list_in[i]) begin
                                    q_idx.push_back(i);
                                    q_addr.push_back(m_first + 32'(4 * m_k));
                                    m_k++;
                                end
                            end
                            m_phase = (m_n == 0) ? PDone : PXfer;
                        end
                    end
                    PXfer: begin
                        if (mem_ready_in) begin
                            void'(q_idx.pop_front());
                            void'(q_addr.pop_front());
                            if (q_idx.size() == 0) m_phase = PDone;
                        end
                    end
                    default: m_phase = PIdle;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk_in);
            if (reset_in || m_phase == PIdle) begin
                chk("idle_ctl", 64'({mem_req_out, mem_we_out, reg_we_out, wb_en_out,
                                     busy_out, done_out, reg_addr_out}), 64'd0);
                chk("idle_mem_addr", 64'(mem_addr_out), 64'd0);
                chk("idle_wb_addr", 64'(wb_addr_out), 64'd0);
            end else if (m_phase == PXfer) begin
                chk("xfer_ctl", 64'({mem_req_out, mem_we_out, busy_out, done_out, wb_en_out}),
                    64'({1'b1, ~m_load, 1'b1, 1'b0, 1'b0}));
                chk("xfer_reg_addr", 64'(reg_addr_out), 64'(q_idx[0]));
                chk("xfer_mem_addr", 64'(mem_addr_out), 64'(q_addr[0]));
                chk("xfer_reg_we", 64'(reg_we_out), 64'(mem_ready_in & m_load));
            end else begin
                chk("done_ctl", 64'({mem_req_out, mem_we_out, reg_we_out, busy_out,
                                     done_out, wb_en_out}),
                    64'({5'b00011, m_wb_en}));
                chk("done_wb_addr", 64'(wb_addr_out), 64'(m_wb));
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic        we;
        logic        rwe;
    } beat_t;

    beat_t       log_q[$];
    int          done_cyc;
    logic        wb_en_seen;
    logic [31:0] wb_addr_seen;
    logic [15:0] r_list;
    logic [31:0] r_base;

    // One transfer; cycle 1 is the cycle whose closing edge samples start.
    task automatic run_xfer(input logic [15:0] list, input logic [31:0] base,
                            input logic p, input logic u, input logic l, input logic w,
                            input int stall_beat, input int stall_len,
                            input bit rnd_ready, input int pulse_cyc, input bit skip_wait);
        int cyc;
        int beats;
        int stall_cnt;
        log_q.delete();
        done_cyc = -1;
        wb_en_seen = 1'b0;
        wb_addr_seen = '0;
        if (!skip_wait) begin
            @(posedge clk_in);
            #1;
        end
        start_in = 1'b1;
        reg_list_in = list;
        base_addr_in = base;
        p_bit_in = p;
        u_bit_in = u;
        l_bit_in = l;
        w_bit_in = w;
        mem_ready_in = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        cyc = 1;
        beats = 0;
        stall_cnt = 0;
        while (cyc < 300) begin
            @(negedge clk_in);
            if (mem_req_out && mem_ready_in) begin
                log_q.push_back('{int'(reg_addr_out), mem_addr_out, mem_we_out, reg_we_out});
                beats++;
            end
            if (done_out) begin
                done_cyc = cyc;
                wb_en_seen = wb_en_out;
                wb_addr_seen = wb_addr_out;
                break;
            end
            @(posedge clk_in);
            #1;
            cyc++;
            if (cyc == pulse_cyc) begin
                // Stray request while busy; must have no effect
                start_in = 1'b1;
                reg_list_in = 16'($urandom);
                base_addr_in = $urandom;
                p_bit_in = ~p;
                u_bit_in = ~u;
                l_bit_in = ~l;
            end else begin
                start_in = 1'b0;
            end
            if (rnd_ready)
                mem_ready_in = ($urandom_range(0, 3) != 0);
            else if (beats == stall_beat && stall_cnt < stall_len) begin
                mem_ready_in = 1'b0;
                stall_cnt++;
            end else
                mem_ready_in = 1'b1;
        end
        start_in = 1'b0;
        chk("done_seen", 64'(done_out), 64'd1);
    endtask

    task automatic check_beat(input string name, input int k, input int idx,
                              input logic [31:0] addr, input logic we, input logic rwe);
        if (k < log_q.size()) begin
            chk({name, "_idx"}, 64'(log_q[k].idx), 64'(idx));
            chk({name, "_addr"}, 64'(log_q[k].addr), 64'(addr));
            chk({name, "_we_rwe"}, 64'({log_q[k].we, log_q[k].rwe}), 64'({we, rwe}));
        end else begin
            total++;
            bad++;
            $display("FAIL %s: got no beat %0d, expected R%0d@0x%0h", name, k, idx, addr);
        end
    endtask

    initial begin
        reset_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_ctl", 64'({mem_req_out, mem_we_out, reg_we_out, wb_en_out, busy_out,
                              done_out, reg_addr_out}), 64'd0);
        chk("reset_addr", 64'({mem_addr_out, wb_addr_out}), 64'd0);
        reset_in = 1'b0;

        // STMIA 0x000B @0x1000, W=0
        run_xfer(16'h000B, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 0, 1'b0);
        chk("stmia_beats", 64'(log_q.size()), 64'd3);
        check_beat("stmia_b0", 0, 0, 32'h0000_1000, 1'b1, 1'b0);
        check_beat("stmia_b1", 1, 1, 32'h0000_1004, 1'b1, 1'b0);
        check_beat("stmia_b2", 2, 3, 32'h0000_1008, 1'b1, 1'b0);
        chk("stmia_done_cyc", 64'(done_cyc), 64'd5);
        chk("stmia_wb_en", 64'(wb_en_seen), 64'd0);

        // LDMDB 0x8001 @0x2000, W=1
        run_xfer(16'h8001, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0, 0, 1'b0);
        chk("ldmdb_beats", 64'(log_q.size()), 64'd2);
        check_beat("ldmdb_b0", 0, 0, 32'h0000_1FF8, 1'b0, 1'b1);
        check_beat("ldmdb_b1", 1, 15, 32'h0000_1FFC, 1'b0, 1'b1);
        chk("ldmdb_done_cyc", 64'(done_cyc), 64'd4);
        chk("ldmdb_wb", 64'({wb_en_seen, wb_addr_seen}), 64'({1'b1, 32'h0000_1FF8}));

        // LDMIB 0x0006 @0xFFFFFFF8, W=1, wraps through zero
        run_xfer(16'h0006, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0, 0, 1'b0);
        chk("ldmib_beats", 64'(log_q.size()), 64'd2);
        check_beat("ldmib_b0", 0, 1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        check_beat("ldmib_b1", 1, 2, 32'h0000_0000, 1'b0, 1'b1);
        chk("ldmib_wb", 64'({wb_en_seen, wb_addr_seen}), 64'({1'b1, 32'h0000_0000}));

        // LDMIA 0x00F0 @0x3000 with 3 wait states on beat 2
        run_xfer(16'h00F0, 32'h0000_3000, 1'b0, 1'b1, 1'b1, 1'b0, 1, 3, 1'b0, 0, 1'b0);
        chk("stall_beats", 64'(log_q.size()), 64'd4);
        check_beat("stall_b0", 0, 4, 32'h0000_3000, 1'b0, 1'b1);
        check_beat("stall_b1", 1, 5, 32'h0000_3004, 1'b0, 1'b1);
        check_beat("stall_b3", 3, 7, 32'h0000_300C, 1'b0, 1'b1);
        chk("stall_done_cyc", 64'(done_cyc), 64'd9);

        // Empty list, W=1: no beats, done next cycle, no writeback
        run_xfer(16'h0000, 32'h0000_5000, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1'b0, 2, 1'b0);
        chk("empty_beats", 64'(log_q.size()), 64'd0);
        chk("empty_done_cyc", 64'(done_cyc), 64'd2);
        chk("empty_wb_en", 64'(wb_en_seen), 64'd0);

        // Start pulsed mid-transfer is ignored
        run_xfer(16'h0003, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 2, 1'b0);
        chk("ignore_beats", 64'(log_q.size()), 64'd2);
        check_beat("ignore_b0", 0, 0, 32'h0000_0100, 1'b0, 1'b1);
        check_beat("ignore_b1", 1, 1, 32'h0000_0104, 1'b0, 1'b1);
        chk("ignore_done_cyc", 64'(done_cyc), 64'd4);

        // Reset in the middle of a 16-beat load
        @(posedge clk_in);
        #1;
        start_in = 1'b1;
        reg_list_in = 16'hFFFF;
        base_addr_in = 32'h0000_4000;
        p_bit_in = 1'b0;
        u_bit_in = 1'b1;
        l_bit_in = 1'b1;
        w_bit_in = 1'b1;
        mem_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk("busy_before_reset", 64'(busy_out), 64'd1);
        reset_in = 1'b1;
        #1;
        chk("rst_mid_ctl", 64'({mem_req_out, mem_we_out, reg_we_out, wb_en_out, busy_out,
                                done_out, reg_addr_out}), 64'd0);
        chk("rst_mid_addr", 64'({mem_addr_out, wb_addr_out}), 64'd0);
        repeat (2) begin
            @(negedge clk_in);
            chk("rst_hold_done", 64'({done_out, wb_en_out}), 64'd0);
        end
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        // STMIB 0x0011 @0x6000, start on the first edge after reset release
        run_xfer(16'h0011, 32'h0000_6000, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 0, 1'b1);
        chk("restart_beats", 64'(log_q.size()), 64'd2);
        check_beat("restart_b0", 0, 0, 32'h0000_6004, 1'b1, 1'b0);
        check_beat("restart_b1", 1, 4, 32'h0000_6008, 1'b1, 1'b0);
        chk("restart_done_cyc", 64'(done_cyc), 64'd4);
        chk("restart_wb", 64'({wb_en_seen, wb_addr_seen}), 64'({1'b1, 32'h0000_6008}));

        // Randomized transfers, random wait states and stray start pulses
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0: r_list = 16'h0000;
                1: r_list = 16'h0001 << $urandom_range(0, 15);
                default: r_list = 16'($urandom);
            endcase
            r_base = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) r_base = 32'hFFFF_FFC0 | ($urandom & 32'h0000_003C);
            run_xfer(r_list, r_base, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 1'b1,
                     $urandom_range(2, 8), 1'b0);
            chk("rand_beats", 64'(log_q.size()), 64'($countones(r_list)));
            repeat ($urandom_range(0, 2)) @(posedge clk_in);
        end

        @(posedge clk_in);
        @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all address ports.
REQ-002 SHALL have port clk_in, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start_in, input, 1 bit: block-transfer request, sampled only in IDLE.
REQ-005 SHALL have port reg_list_in, input, 16 bits: register list, bit n selects Rn; captured with start_in.
REQ-006 SHALL have port base_addr_in, input, ADDR_W bits: base register value; captured with start_in.
REQ-007 SHALL have ports p_bit_in, u_bit_in, l_bit_in and w_bit_in, inputs, 1 bit each: pre-index, up, load (1) / store (0) and writeback; captured with start_in.
REQ-008 SHALL have port mem_ready_in, input, 1 bit: memory accepts/returns the current beat.
REQ-009 SHALL have port mem_req_out, output, 1 bit: memory beat request.
REQ-010 SHALL have port mem_we_out, output, 1 bit: store beat when 1.
REQ-011 SHALL have port mem_addr_out, output, ADDR_W bits: word address of the current beat.
REQ-012 SHALL have port reg_addr_out, output, 4 bits: register index of the current beat.
REQ-013 SHALL have port reg_we_out, output, 1 bit: load-data write strobe to the register file.
REQ-014 SHALL have ports wb_en_out, output, 1 bit, and wb_addr_out, output, ADDR_W bits: base writeback strobe and value.
REQ-015 SHALL have ports busy_out and done_out, outputs, 1 bit each: busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM IDLE -> XFER -> DONE -> IDLE; an empty list goes IDLE -> DONE.
REQ-017 SHALL, on a clock edge in IDLE with start_in=1, capture all inputs, load the pending mask with reg_list_in, compute N=popcount(reg_list_in) and enter XFER; start_in is ignored outside IDLE.
REQ-018 SHALL compute the first address modulo 2^ADDR_W as follows: IA (P=0,U=1) base; IB (P=1,U=1) base+4; DA (P=0,U=0) base-4N+4; DB (P=1,U=0) base-4N.
REQ-019 SHALL, in XFER, drive mem_req_out=1, mem_we_out=~L, reg_addr_out=lowest set bit of the pending mask, and mem_addr_out=current address.
REQ-020 SHALL treat a beat as complete on the cycle where mem_req_out=1 and mem_ready_in=1; on that edge it clears the pending bit and adds 4 to the address with wrap-around.
REQ-021 SHALL hold all XFER outputs stable while mem_ready_in=0, for unbounded wait states.
REQ-022 SHALL drive reg_we_out = mem_req_out & mem_ready_in & L (combinational); reg_we_out SHALL be 0 for stores.
REQ-023 SHALL transfer registers in ascending index order at ascending addresses in every mode.
REQ-024 SHALL enter DONE on the completing edge of the last beat, so there are no idle cycles between beats when mem_ready_in is held high.
REQ-025 SHALL, in DONE, pulse done_out=1 for one cycle and return to IDLE on the next edge.
REQ-026 SHALL, in DONE, drive wb_en_out=W and wb_addr_out=base+4N if U=1 or base-4N if U=0, both mod 2^ADDR_W.
REQ-027 SHALL, for an empty list (N=0), issue no memory beats, pulse done_out one cycle after start, and keep wb_en_out=0.
REQ-028 SHALL drive mem_req_out, mem_we_out, reg_we_out, wb_en_out and done_out to 0 outside their states, and drive the address outputs to 0 in IDLE.
REQ-029 SHALL give a minimum latency of N+2 cycles from the start edge to done_out with zero wait states.

Reset
REQ-030 SHALL, while reset_in=1, asynchronously force the FSM to IDLE, the pending mask and the internal address to 0, and every output to 0, including mid-transfer.
REQ-031 SHALL leave no partial writeback or done pulse after a reset mid-operation, and SHALL accept a new start on the first edge after reset deasserts.

Verification
REQ-032 SHALL cover: STMIA list 0x000B, base 0x1000, mem_ready=1 -> beats R0@0x1000, R1@0x1004, R3@0x1008 with we=1; done on cycle 5; wb_en=0 (W=0).
REQ-033 SHALL cover: LDMDB list 0x8001, base 0x2000, W=1 -> R0@0x1FF8, R15@0x1FFC; reg_we on both beats; wb_addr=0x1FF8.
REQ-034 SHALL cover: LDMIB list 0x0006, base 0xFFFFFFF8, W=1 -> R1@0xFFFFFFFC, R2@0x00000000; wb_addr=0x00000000 (wrap).
REQ-035 SHALL cover: mem_ready low for 3 cycles on beat 2 -> outputs held, no reg_we, beat 2 then completes normally.
REQ-036 SHALL cover: empty list -> no mem_req, done one cycle after start; and start pulsed during XFER -> ignored.
REQ-037 SHALL cover: reset_in asserted mid-XFER -> outputs 0 immediately, no done; restart succeeds.
